instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch/issue front end of the 8-bit, 4-opcode CPU: holds the PC, reads one instruction word per
//  fetch from instruction memory over a req/ack handshake, and presents op/rs/rt/rd fields to the
//  opcode decoder and register file with a valid/ready handshake. Resolves jumps (op 2'b11) locally.
//  Sits between instruction memory and the decode stage; the decode stage is the sole consumer.
// PARAMETERS
//  PC_W     8   PC / instruction-memory address width
//  CNT_W    16  width of retired-issue counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  run          in   1      level; 1 = start/continue fetching
//  halt         in   1      level; stop at next instruction boundary
//  imem_req     out  1      fetch request, held until imem_ack
//  imem_addr    out  PC_W   fetch address (= pc), stable while imem_req
//  imem_rdata   in   8      instruction word, valid when imem_ack
//  imem_ack     in   1      1-cycle ack; may arrive in the same cycle imem_req rises
//  issue_valid  out  1      instruction fields valid
//  issue_ready  in   1      decode accepts when valid & ready
//  op           out  2      instr[7:6], to decoder op input
//  rs,rt,rd     out  2 each instr[5:4], [3:2], [1:0]
//  issue_pc     out  PC_W   address of issued instruction
//  halted       out  1      1 in HALT state
//  issue_cnt    out  CNT_W  count of accepted issues, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; pc=0; all outputs 0 (imem_addr=0, op/rs/rt/rd=0, issue_cnt=0).
//  Opcodes: 00 R-type, 01 LW, 10 SW, 11 J. Jump target = pc+1+sext(instr[5:0]), mod 2^PC_W.
//  FSM (registered state):
//   IDLE : run=1 & halt=0 -> FETCH; else stay.
//   FETCH: imem_req=1, imem_addr=pc. On imem_ack: latch imem_rdata into instr reg; next pc =
//          jump target if op==11 else pc+1; -> ISSUE. No ack -> stay, req/addr held.
//   ISSUE: issue_valid=1, fields from instr reg, stable until accepted. On valid&ready:
//          issue_cnt++ (saturate at all-ones); -> HALT if halt=1 or run=0 (sampled same cycle), else FETCH.
//   HALT : halted=1; imem_req=0, issue_valid=0. Leaves to FETCH only when run=1 & halt=0; pc retained.
//  Latency: min 2 cycles/instruction (ack in first FETCH cycle, ready held high).
//  Boundaries:
//   - pc wraps 8'hFF -> 8'h00 (sequential and jump arithmetic alike); no error flag.
//   - J with offset 6'h3F (-1) targets itself: legal, loops forever; halt still terminates it.
//   - halt/run change during FETCH: outstanding request always completes and is issued; never dropped.
//   - issue_ready high while issue_valid low: ignored. Jumps are issued (decoder needs Branch).
//   - rst_n asserted mid-FETCH/ISSUE: immediate return to reset values; in-flight word discarded.
//   - imem_ack outside FETCH: ignored.
// STRUCTURE
//  Shared include isa_defs.vh: OP_RTYPE/OP_LW/OP_SW/OP_J codes, field bit positions, state encodings.
//  One sub-module: pc_next_calc (comb: pc, instr -> next pc, incl. sign-extend and wrap).
//  Top: FSM, pc reg, instr reg, issue counter.
// TESTING
//  1 Reset, run=1, mem[0..2]=8'h1B,8'h64,8'h98, ack same cycle, ready=1 -> ops 00,01,10 at pc 0,1,2,
//    issue_valid every 2nd cycle, issue_cnt=3.
//  2 mem[4]=8'hC2 (J +2) -> issued op=11 issue_pc=4, next imem_addr=7.
//  3 mem[5]=8'hFF (J -1) -> imem_addr 5 repeatedly; assert halt -> halted=1 after current issue, pc=5.
//  4 ack delayed 3 cycles, ready low 4 cycles -> req/addr and fields held stable, no dup/missed issue.
//  5 pc=8'hFF, non-jump -> next imem_addr=8'h00; J at 8'hFE with +5 -> target 8'h04.
//  6 rst_n low mid-FETCH and mid-ISSUE -> all outputs 0 same cycle; restart fetches addr 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA and FSM definitions for the instruction fetch front end.
// Opcode codes, instruction field positions and state encodings live here.
package instr_fetch_unit_pkg;

  localparam logic [1:0] OP_J = 2'b11;

  localparam int OP_MSB = 7;
  localparam int RS_MSB = 5;
  localparam int RT_MSB = 3;
  localparam int RD_MSB = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  function automatic logic is_jump(input logic [7:0] instr);
    return (instr[OP_MSB -: 2] == OP_J);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC calculation: sequential increment or pc+1+sext(instr[5:0]) for jumps.
// All arithmetic wraps modulo 2^PC_W.
module pc_next_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [7:0]      i_instr,
  output logic [PC_W-1:0] o_next_pc
);

  logic [PC_W-1:0] w_seq_pc;
  logic [PC_W-1:0] w_offset;

  assign w_seq_pc  = i_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_offset  = {{(PC_W-6){i_instr[5]}}, i_instr[5:0]};
  assign o_next_pc = is_jump(i_instr) ? (w_seq_pc + w_offset) : w_seq_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/issue front end: PC, instruction-memory req/ack fetch, valid/ready issue to decode,
// local jump resolution and a saturating count of accepted issues.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             halt,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [7:0]       imem_rdata,
  input  logic             imem_ack,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [1:0]       op,
  output logic [1:0]       rs,
  output logic [1:0]       rt,
  output logic [1:0]       rd,
  output logic [PC_W-1:0]  issue_pc,
  output logic             halted,
  output logic [CNT_W-1:0] issue_cnt
);

  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic [7:0]       r_instr;
  logic [PC_W-1:0]  r_issue_pc;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [PC_W-1:0]  w_next_pc;

  // Next PC is computed from the word arriving with the ack so it can be latched on the same edge.
  pc_next_calc #(.PC_W(PC_W)) u_pc_next (
    .i_pc      (r_pc),
    .i_instr   (imem_rdata),
    .o_next_pc (w_next_pc)
  );

  // FSM, PC, instruction register and issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_instr     <= 8'h00;
      r_issue_pc  <= '0;
      r_issue_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run && !halt) r_state <= S_FETCH;
          else              r_state <= S_IDLE;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_instr    <= imem_rdata;
            r_issue_pc <= r_pc;
            r_pc       <= w_next_pc;
            r_state    <= S_ISSUE;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            if (r_issue_cnt != {CNT_W{1'b1}})
              r_issue_cnt <= r_issue_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            else
              r_issue_cnt <= r_issue_cnt;
            // halt/run are only honoured at an instruction boundary, i.e. on acceptance
            if (halt || !run) r_state <= S_HALT;
            else              r_state <= S_FETCH;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_HALT: begin
          if (run && !halt) r_state <= S_FETCH;
          else              r_state <= S_HALT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign issue_valid = (r_state == S_ISSUE);
  assign halted      = (r_state == S_HALT);
  assign op          = r_instr[OP_MSB -: 2];
  assign rs          = r_instr[RS_MSB -: 2];
  assign rt          = r_instr[RT_MSB -: 2];
  assign rd          = r_instr[RD_MSB -: 2];
  assign issue_pc    = r_issue_pc;
  assign issue_cnt   = r_issue_cnt;

endmodule
